// File: rtl/ctr_mon_pkg.sv
// Shared types and constants for the counter match monitor.
package ctr_mon_pkg;

    localparam int unsigned CTR_WIDTH  = 4;
    localparam int unsigned WRAP_WIDTH = 8;

    localparam logic [CTR_WIDTH-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        COUNT_WRAPS = 2'd1,
        WAIT_MATCH  = 2'd2,
        DONE        = 2'd3
    } mon_state_t;

endpackage

// File: rtl/ctr_seq_checker.sv
// Tracks the previous counter sample and flags wraps and non-+1 steps.
module ctr_seq_checker
    import ctr_mon_pkg::*;
#(
    parameter int unsigned WIDTH = CTR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] ctr,
    output logic             prev_valid,
    output logic             wrap_hit,
    output logic             err_hit
);

    localparam logic [WIDTH-1:0] CTR_MAX = '1;

    logic [WIDTH-1:0] prev_ctr;
    logic [WIDTH-1:0] expected;
    logic             load_d;
    logic             checked;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_ctr   <= '0;
            load_d     <= 1'b0;
            prev_valid <= 1'b0;
        end else begin
            prev_ctr   <= ctr;
            load_d     <= load;
            prev_valid <= 1'b1;
        end
    end

    // A sample right after a load is the loaded value, so it is never judged.
    always_comb begin
        checked  = prev_valid && !load_d;
        expected = prev_ctr + WIDTH'(1);
        wrap_hit = checked && (prev_ctr == CTR_MAX) && (ctr == '0);
        err_hit  = checked && (ctr != expected);
    end

endmodule

// File: rtl/ctr_match_monitor.sv
// Watches a loadable counter: reports wraps, sequence errors and an armed
// "N wraps then match value" trigger.
module ctr_match_monitor
    import ctr_mon_pkg::*;
#(
    parameter int unsigned WIDTH  = CTR_WIDTH,
    parameter int unsigned WRAP_W = WRAP_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WIDTH-1:0]  ctr,
    input  logic              arm,
    input  logic [WIDTH-1:0]  cmp_val,
    input  logic [WRAP_W-1:0] wrap_goal,
    input  logic              clr_err,
    output logic              wrap_pulse,
    output logic              match_pulse,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              seq_err
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    mon_state_t        state, state_nxt;
    logic [WIDTH-1:0]  cmp_lat;
    logic [WRAP_W-1:0] goal_lat;
    logic [WRAP_W-1:0] wrap_inc;
    logic              prev_valid;
    logic              wrap_hit;
    logic              err_hit;
    logic              latch_arm;
    logic              match_hit;

    ctr_seq_checker #(.WIDTH(WIDTH)) u_checker (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .ctr        (ctr),
        .prev_valid (prev_valid),
        .wrap_hit   (wrap_hit),
        .err_hit    (err_hit)
    );

    always_comb begin
        state_nxt = state;
        latch_arm = 1'b0;
        match_hit = 1'b0;
        wrap_inc  = (wrap_count == WRAP_MAX) ? wrap_count : wrap_count + WRAP_W'(1);
        case (state)
            IDLE, DONE: begin
                if (arm) begin
                    latch_arm = 1'b1;
                    state_nxt = (wrap_goal == '0) ? WAIT_MATCH : COUNT_WRAPS;
                end
            end
            COUNT_WRAPS: begin
                if (wrap_hit && (wrap_inc == goal_lat)) begin
                    state_nxt = WAIT_MATCH;
                end
            end
            WAIT_MATCH: begin
                if (prev_valid && (ctr == cmp_lat)) begin
                    match_hit = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cmp_lat     <= '0;
            goal_lat    <= '0;
            wrap_count  <= '0;
            wrap_pulse  <= 1'b0;
            match_pulse <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wrap_pulse  <= wrap_hit;
            match_pulse <= match_hit;
            // A fresh error outranks a simultaneous clear.
            if (err_hit) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
            if (latch_arm) begin
                cmp_lat    <= cmp_val;
                goal_lat   <= wrap_goal;
                wrap_count <= '0;
            end else if ((state == COUNT_WRAPS) && wrap_hit) begin
                wrap_count <= wrap_inc;
            end
        end
    end

    always_comb begin
        busy = (state == COUNT_WRAPS) || (state == WAIT_MATCH);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_ctr_match_monitor.sv
// Bench for ctr_match_monitor: a behavioural loadable counter for the
// free-running tests, then a directly driven vector table.
module tb_ctr_match_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       arm = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] cmp_val = '0;
    logic [7:0] wrap_goal = '0;
    logic [3:0] l_data = '0;
    logic [3:0] cnt = '0;
    logic [3:0] ctr_drv = '0;
    logic       direct = 1'b0;
    logic [3:0] ctr;

    logic       wrap_pulse, match_pulse, busy, done, seq_err;
    logic [7:0] wrap_count;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    // Stand-in for the upstream synchronous loadable 4-bit counter.
    always @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= l_data;
        else           cnt <= cnt + 4'd1;
    end

    assign ctr = direct ? ctr_drv : cnt;

    ctr_match_monitor #(.WIDTH(4), .WRAP_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .ctr         (ctr),
        .arm         (arm),
        .cmp_val     (cmp_val),
        .wrap_goal   (wrap_goal),
        .clr_err     (clr_err),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse),
        .busy        (busy),
        .done        (done),
        .wrap_count  (wrap_count),
        .seq_err     (seq_err)
    );

    typedef struct {
        logic       rst;
        logic       load;
        logic [3:0] ctr;
        logic       arm;
        logic [3:0] cmp;
        logic [7:0] goal;
        logic       clr;
        logic       wrap;
        logic       match;
        logic       busy;
        logic       done;
        logic [7:0] wcnt;
        logic       serr;
    } vec_t;

    localparam int NV = 34;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic l, input logic [3:0] c,
                                input logic a, input logic [3:0] cm, input logic [7:0] g,
                                input logic cl, input logic w, input logic m,
                                input logic b, input logic d, input logic [7:0] wc,
                                input logic se);
        vec_t v;
        v.rst = r; v.load = l; v.ctr = c; v.arm = a; v.cmp = cm; v.goal = g; v.clr = cl;
        v.wrap = w; v.match = m; v.busy = b; v.done = d; v.wcnt = wc; v.serr = se;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic w, input logic m, input logic b,
                           input logic d, input logic [7:0] wc, input logic se);
        chk({tag, " wrap_pulse"},  {7'd0, wrap_pulse},  {7'd0, w});
        chk({tag, " match_pulse"}, {7'd0, match_pulse}, {7'd0, m});
        chk({tag, " busy"},        {7'd0, busy},        {7'd0, b});
        chk({tag, " done"},        {7'd0, done},        {7'd0, d});
        chk({tag, " wrap_count"},  wrap_count,          wc);
        chk({tag, " seq_err"},     {7'd0, seq_err},     {7'd0, se});
    endtask

    task automatic wait_cnt(input logic [3:0] v);
        int unsigned n = 0;
        while (cnt != v && n < 40) begin
            step();
            n++;
        end
        chk("wait_cnt reached", {4'd0, cnt}, {4'd0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rst ld ctr arm cmp goal clr | wr ma bu dn wc se
        vecs[0]  = mk(1, 0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,  3, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0,  7, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[3]  = mk(0, 0,  7, 0,  0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[4]  = mk(0, 0,  8, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1,  9, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0,  7, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0,  2, 0,  0, 0, 1,  0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(0, 0,  3, 0,  0, 0, 1,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0,  4, 1, 12, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[10] = mk(0, 0,  5, 1,  7, 3, 0,  0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 0,  6, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[12] = mk(0, 0,  7, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[13] = mk(0, 0,  8, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[14] = mk(0, 0,  9, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[15] = mk(0, 0, 10, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[16] = mk(0, 0, 11, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[17] = mk(0, 0, 12, 0,  0, 0, 0,  0, 1, 0, 1, 0, 0);
        vecs[18] = mk(0, 0, 13, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
        vecs[19] = mk(0, 0, 14, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
        vecs[20] = mk(0, 0, 15, 0,  0, 0, 0,  0, 0, 0, 1, 0, 0);
        vecs[21] = mk(0, 0,  0, 0,  0, 0, 0,  1, 0, 0, 1, 0, 0);
        vecs[22] = mk(0, 0,  1, 1,  1, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[23] = mk(0, 1,  2, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[24] = mk(0, 0,  1, 0,  0, 0, 0,  0, 1, 0, 1, 0, 0);
        vecs[25] = mk(0, 0,  2, 1,  9, 1, 0,  0, 0, 1, 0, 0, 0);
        vecs[26] = mk(0, 1,  3, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[27] = mk(0, 0, 14, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[28] = mk(0, 0, 15, 0,  0, 0, 0,  0, 0, 1, 0, 0, 0);
        vecs[29] = mk(0, 0,  0, 0,  0, 0, 0,  1, 0, 1, 0, 1, 0);
        vecs[30] = mk(0, 0,  1, 0,  0, 0, 0,  0, 0, 1, 0, 1, 0);
        vecs[31] = mk(1, 0,  9, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[32] = mk(0, 0,  5, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);
        vecs[33] = mk(0, 0,  6, 0,  0, 0, 0,  0, 0, 0, 0, 0, 0);

        // Free run from reset: a single wrap pulse on the edge that samples 15->0.
        rst = 1'b1;
        step();
        chk_all("reset", 0, 0, 0, 0, 8'd0, 0);
        rst = 1'b0;
        for (int i = 1; i <= 19; i++) begin
            step();
            chk($sformatf("freerun%0d wrap_pulse", i), {7'd0, wrap_pulse}, {7'd0, (i == 17)});
            chk($sformatf("freerun%0d seq_err", i), {7'd0, seq_err}, 8'd0);
        end

        // Arm cmp=5 goal=1 while the counter shows 3.
        arm = 1'b1; cmp_val = 4'd5; wrap_goal = 8'd1;
        step();
        arm = 1'b0; cmp_val = '0; wrap_goal = '0;
        chk_all("armed", 0, 0, 1, 0, 8'd0, 0);
        for (int i = 4; i <= 15; i++) begin
            step();
            chk($sformatf("pre-wrap ctr%0d match_pulse", i), {7'd0, match_pulse}, 8'd0);
        end
        step();
        chk_all("goal wrap", 1, 0, 1, 0, 8'd1, 0);
        for (int i = 1; i <= 4; i++) begin
            step();
            chk($sformatf("pre-match ctr%0d match_pulse", i), {7'd0, match_pulse}, 8'd0);
        end
        step();
        chk_all("match at 5", 0, 1, 0, 1, 8'd1, 0);
        step();
        chk_all("after match", 0, 0, 0, 1, 8'd1, 0);

        // Load 9 at 4, then load 0 at 15: neither is an error nor a wrap.
        wait_cnt(4'd4);
        load = 1'b1; l_data = 4'd9;
        step();
        load = 1'b0;
        chk("load9 edge seq_err", {7'd0, seq_err}, 8'd0);
        step();
        chk("after load9 ctr", {4'd0, ctr}, 8'd10);
        chk("load9 sample seq_err", {7'd0, seq_err}, 8'd0);
        chk("load9 sample wrap", {7'd0, wrap_pulse}, 8'd0);
        step();
        chk("post load9 seq_err", {7'd0, seq_err}, 8'd0);
        wait_cnt(4'd15);
        load = 1'b1; l_data = 4'd0;
        step();
        load = 1'b0;
        chk("load0 edge wrap", {7'd0, wrap_pulse}, 8'd0);
        step();
        chk("load0 sample wrap", {7'd0, wrap_pulse}, 8'd0);
        step();
        chk("post load0 wrap", {7'd0, wrap_pulse}, 8'd0);
        chk("post load0 seq_err", {7'd0, seq_err}, 8'd0);

        // Directly driven table: sequence errors, arm/ignore, load-match, reset mid-run.
        direct = 1'b1;
        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; load = vecs[i].load; ctr_drv = vecs[i].ctr;
            arm = vecs[i].arm; cmp_val = vecs[i].cmp; wrap_goal = vecs[i].goal;
            clr_err = vecs[i].clr;
            step();
            chk_all($sformatf("row%0d", i), vecs[i].wrap, vecs[i].match, vecs[i].busy,
                    vecs[i].done, vecs[i].wcnt, vecs[i].serr);
        end
        rst = 1'b0; load = 1'b0; arm = 1'b0; clr_err = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
